timing_frame_encoder: RTL

Generates the 10-bit 8b/10b line words that feed the DDR timing serializer, one word per clk_par cycle. It merges three sources into a single word stream with fixed priority: single-word trigger markers, periodic bunch-counter-reset (BCR) markers, and host commands framed with sequence number and checksum. It keeps running disparity and a bunch-crossing counter, and drives `enc_word`, which connects directly to the serializer's parallel input. The serializer transmits `enc_word[9]` first.

---
 rtl/timing_frame_encoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/timing_frame_encoder.sv
// timing_frame_encoder: arbitrates triggers, BCR markers and framed host commands
// into one 8b/10b line word per clk_par cycle for the DDR timing serializer.
module timing_frame_encoder #(
    parameter int BC_PERIOD = 3564
) (
    input  logic        clk_par,
    input  logic        reset_n,
    input  logic        trig,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_type,
    input  logic [7:0]  cmd_data,
    output logic [9:0]  enc_word,
    output logic [11:0] bcid,
    output logic        trig_lost
);
    typedef enum logic [2:0] {IDLE, SOF, D0, D1, D2, EOF} state_t;

    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;

    function automatic logic [5:0] code6(input logic [4:0] x);
        case (x)
            5'd0:    return 6'b100111;
            5'd1:    return 6'b011101;
            5'd2:    return 6'b101101;
            5'd3:    return 6'b110001;
            5'd4:    return 6'b110101;
            5'd5:    return 6'b101001;
            5'd6:    return 6'b011001;
            5'd7:    return 6'b111000;
            5'd8:    return 6'b111001;
            5'd9:    return 6'b100101;
            5'd10:   return 6'b010101;
            5'd11:   return 6'b110100;
            5'd12:   return 6'b001101;
            5'd13:   return 6'b101100;
            5'd14:   return 6'b011100;
            5'd15:   return 6'b010111;
            5'd16:   return 6'b011011;
            5'd17:   return 6'b100011;
            5'd18:   return 6'b010011;
            5'd19:   return 6'b110010;
            5'd20:   return 6'b001011;
            5'd21:   return 6'b101010;
            5'd22:   return 6'b011010;
            5'd23:   return 6'b111010;
            5'd24:   return 6'b110011;
            5'd25:   return 6'b100110;
            5'd26:   return 6'b010110;
            5'd27:   return 6'b110110;
            5'd28:   return 6'b001110;
            5'd29:   return 6'b101110;
            5'd30:   return 6'b011110;
            default: return 6'b101011;
        endcase
    endfunction

    // Tables hold the RD- forms; sub-blocks are complemented when the disparity in front of them is positive.
    function automatic logic [9:0] encode(input logic k, input logic [7:0] b, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       rd_mid;
        logic       alt7;
        logic       flip4;
        x = b[4:0];
        y = b[7:5];
        c6 = k ? 6'b001111 : code6(x);
        rd_mid = ($countones(c6) == 3) ? rd : ~rd;
        c6 = (rd && ($countones(c6) != 3 || (!k && x == 5'd7))) ? ~c6 : c6;
        alt7 = k || (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                            : (x == 5'd17 || x == 5'd18 || x == 5'd20));
        c4 = y == 3'd0 ? 4'b1011 : y == 3'd1 ? 4'b1001 : y == 3'd2 ? 4'b0101 :
             y == 3'd3 ? 4'b1100 : y == 3'd4 ? 4'b1101 : y == 3'd5 ? 4'b1010 :
             y == 3'd6 ? 4'b0110 : alt7 ? 4'b0111 : 4'b1110;
        flip4 = y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7;
        c4 = ((rd_mid && flip4) || (k && !rd_mid && !flip4)) ? ~c4 : c4;
        return {c6, c4};
    endfunction

    state_t      state_q, state_d;
    logic        run_q;
    logic        trig_pend_q, trig_pend_d;
    logic        bcr_pend_q, bcr_pend_d;
    logic        rd_q, rd_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [11:0] bcid_q, bcid_d;
    logic [3:0]  seq_q, seq_d;
    logic [7:0]  d0_q, d0_d;
    logic [7:0]  d1_q, d1_d;
    logic [9:0]  enc_word_q, enc_word_d;
    logic        grant_trig, grant_bcr, grant_frame, handshake, wrap, word_k;
    logic [7:0]  frame_byte, word_byte;

    always_comb begin
        grant_trig  = trig_pend_q;
        grant_bcr   = bcr_pend_q && !trig_pend_q;
        grant_frame = state_q != IDLE && !trig_pend_q && !bcr_pend_q;
        handshake   = cmd_valid && cmd_ready_q;
        wrap        = bcid_q == 12'(BC_PERIOD - 1);
        bcid_d      = wrap ? 12'd0 : bcid_q + 12'd1;
        trig_pend_d = trig || (trig_pend_q && !grant_trig);
        bcr_pend_d  = wrap || (bcr_pend_q && !grant_bcr);
        trig_lost   = trig && trig_pend_q && !grant_trig;
        seq_d       = handshake ? seq_q + 4'd1 : seq_q;
        d0_d        = handshake ? {cmd_type, seq_q} : d0_q;
        d1_d        = handshake ? cmd_data : d1_q;
        frame_byte  = state_q == SOF ? K28_2 : state_q == D0 ? d0_q : state_q == D1 ? d1_q :
                      state_q == D2 ? (d0_q ^ d1_q ^ 8'h5A) : K28_6;
        word_k      = !(grant_frame && (state_q == D0 || state_q == D1 || state_q == D2));
        word_byte   = grant_trig ? K28_1 : grant_bcr ? K28_3 : grant_frame ? frame_byte : K28_5;
        enc_word_d  = encode(word_k, word_byte, rd_q);
        rd_d        = ($countones(enc_word_d) == 5) ? rd_q : ($countones(enc_word_d) > 5);
        state_d     = handshake ? SOF : !grant_frame ? state_q :
                      state_q == EOF ? IDLE : state_t'(state_q + 3'd1);
        cmd_ready_d = state_d == IDLE;
    end

    // The first edge after release still loads reset values, so cmd_ready rises one cycle later.
    always_ff @(posedge clk_par) begin
        run_q <= reset_n;
        if (!reset_n || !run_q) begin
            state_q     <= IDLE;
            trig_pend_q <= 1'b0;
            bcr_pend_q  <= 1'b0;
            rd_q        <= 1'b0;
            cmd_ready_q <= 1'b0;
            bcid_q      <= 12'd0;
            seq_q       <= 4'd0;
            d0_q        <= 8'd0;
            d1_q        <= 8'd0;
            enc_word_q  <= 10'h0FA;
        end else begin
            state_q     <= state_d;
            trig_pend_q <= trig_pend_d;
            bcr_pend_q  <= bcr_pend_d;
            rd_q        <= rd_d;
            cmd_ready_q <= cmd_ready_d;
            bcid_q      <= bcid_d;
            seq_q       <= seq_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            enc_word_q  <= enc_word_d;
        end
    end

    assign enc_word  = enc_word_q;
    assign bcid      = bcid_q;
    assign cmd_ready = cmd_ready_q;
endmodule
